// File: rtl/seq_slice_adder.sv
// seq_slice_adder: multi-cycle WIDTH-bit adder, one SLICE-bit chunk per clock,
// carry rippled between chunks through a register; valid/ready on both sides.
module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("seq_slice_adder: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state, state_nx;
    logic             started;   // holds in_ready low until the first edge after reset
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             cout_r, ovf_r;

    logic [SLICE-1:0] a_s, b_s;
    logic [SLICE:0]   slice_res;
    logic             msb_cin;

    // Current slice operands and their sum including the rippled carry
    always_comb begin
        a_s       = a_r[int'(idx)*SLICE +: SLICE];
        b_s       = b_r[int'(idx)*SLICE +: SLICE];
        slice_res = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry};
        // carry into the slice MSB, recovered from its sum bit
        msb_cin   = slice_res[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                if (in_valid && started) state_nx = CALC;
            end
            CALC: begin
                if (idx == LAST) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    sum_r[int'(idx)*SLICE +: SLICE] <= slice_res[SLICE-1:0];
                    carry <= slice_res[SLICE];
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout_r <= slice_res[SLICE];
                        ovf_r  <= slice_res[SLICE] ^ msb_cin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;
    assign zero     = out_valid & ~|sum_r;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Scoreboard bench for seq_slice_adder: driver pushes reference results,
// a monitor pops and compares whenever a result is handed over.
module tb_seq_slice_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        cout, overflow, zero;

    seq_slice_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        co, ov, z;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0, total_cnt = 0;
    int   n_issued = 0, n_got = 0;
    int   cyc = 0, last_acc = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: stalled

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // reference: plain 33-bit arithmetic plus sign rule for overflow
    function automatic exp_t ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        exp_t e;
        logic [32:0] full;
        full = {1'b0, x} + {1'b0, y} + {32'd0, c};
        e.s  = full[31:0];
        e.co = full[32];
        e.ov = (x[31] == y[31]) && (e.s[31] != x[31]);
        e.z  = (e.s == 32'd0);
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // monitor: latency on each new result, content on each handover
    initial begin
        exp_t e;
        logic prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev_ov) chk("latency", 64'(cyc - last_acc), 64'd4);
            prev_ov = out_valid;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    n_got++;
                    chk("sum", 64'(sum), 64'(e.s));
                    chk("cout", 64'(cout), 64'(e.co));
                    chk("overflow", 64'(overflow), 64'(e.ov));
                    chk("zero", 64'(zero), 64'(e.z));
                end
            end
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        last_acc = cyc;
        exp_q.push_back(ref_add(x, y, c));
        n_issued++;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] corners [4];
        logic [31:0] s0;
        logic        c0, o0, z0;
        logic [31:0] x, y;
        int          n;
        corners = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outs", 64'({sum, cout, overflow, zero}), 64'd0);
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("in_ready_after_edge", 64'(in_ready), 64'd1);

        // directed corner operands
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        drain();

        // stall in HOLD: outputs stable, stray in_valid not captured
        rdy_mode = 2;
        do_op(32'h0000_00FF, 32'h0000_0000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", 64'(out_valid), 64'd1);
        s0 = sum; c0 = cout; o0 = overflow; z0 = zero;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_stable", 64'({sum, cout, overflow, zero, out_valid}), 64'({s0, c0, o0, z0, 1'b1}));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            if (i == 1) begin
                a = 32'h1234_5678; b = 32'h0; cin = 1'b0; in_valid = 1'b1;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        rdy_mode = 0;
        drain();

        // abort mid-calculation: reset while the third slice is pending
        do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 64'({sum, cout, overflow, zero, out_valid, in_ready}), 64'd0);
        void'(exp_q.pop_back());
        n_issued--;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h0000_0010, 32'h0000_0020, 1'b0);
        drain();

        // randomized operands with random result stalls
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            do_op(x, y, 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_mode = 0;
        repeat (10) @(negedge clk);
        chk("result_count", 64'(n_got), 64'(n_issued));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
